// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset PC, bubble
// encoding, FSM states and the fixed 32-bit MIPS field layout.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package instr_fetch_stage_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned INSTR_W_DEF  = 32;
  localparam logic [31:0] PC_RESET_DEF = 32'h0;
  localparam int unsigned PC_STEP_DEF  = 4;

  // All-zero word decodes as "sll $0,$0,0", which the controller treats as a no-op.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // one quiet cycle after reset, no request
    S_FETCH = 2'd1,  // request outstanding at PC
    S_DRAIN = 2'd2,  // redirected while a request was outstanding; waiting to discard it
    S_HOLD  = 2'd3   // fetched word parked in skid while downstream stalls
  } fetch_state_e;

  // Field layout of a 32-bit MIPS word, MSB first. Imm overlays {rd, shamt, func}.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] func;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(input logic [31:0] instr);
    return instr_fields_t'(instr);
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction memory request/response bus between fetch stage (master) and memory (slave).
// Latency: set by the memory; a transfer completes on any cycle with req_vld & rsp_rdy.
// Backpressure: memory holds off by keeping rsp_rdy low; master keeps req_vld/req_addr stable meanwhile.
interface instr_fetch_stage_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               req_vld;   // fetch request
  logic [ADDR_W-1:0]  req_addr;  // fetch address, stable while req_vld
  logic               rsp_rdy;   // memory completes the request this cycle
  logic [INSTR_W-1:0] rsp_dat;   // instruction word, valid with rsp_rdy

  modport master (output req_vld, req_addr, input rsp_rdy, rsp_dat);
  modport slave  (input req_vld, req_addr, output rsp_rdy, rsp_dat);
endinterface

// File: rtl/instr_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: holds the fetched instruction and its PC+step for decode.
// Latency: 1 cycle from load_i to outputs.
// Backpressure: holds contents whenever load_i is low; flush_i beats load_i.
// Ports: clk_i/rst_n_i; load_i, flush_i controls; instr_i/pc4_i in; valid_o/instr_o/pc4_o out.
module ifid_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc4_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc4_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc4_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      instr_q <= INSTR_W'(NOP_INSTR);
      pc4_q   <= '0;
    end else if (flush_i) begin
      // Flush turns the slot into a bubble; pc4 is meaningless without valid and is left alone.
      valid_q <= 1'b0;
      instr_q <= INSTR_W'(NOP_INSTR);
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage + IF/ID register: owns the PC, fetches over a req/rdy memory bus, decodes fields.
// Latency: rsp_rdy in cycle N -> IF/ID and decoded fields visible in N+1; 1 instr/cycle with 1-cycle memory.
// Backpressure: stall_i freezes IF/ID; a word arriving under stall is parked in a one-entry skid.
// Ports: clk_i, rst_n_i; stall_i, branch_taken_i, branch_target_i; imem (master bus);
//        ifid_valid_o, ifid_instr_o, ifid_pc4_o; opcode_o, func_o, rs_o, rt_o, rd_o, shamt_o, imm_o.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                stall_i,
  input  logic                branch_taken_i,
  input  logic [ADDR_W-1:0]   branch_target_i,
  instr_fetch_stage_if.master imem,
  output logic                ifid_valid_o,
  output logic [INSTR_W-1:0]  ifid_instr_o,
  output logic [ADDR_W-1:0]   ifid_pc4_o,
  output logic [5:0]          opcode_o,
  output logic [5:0]          func_o,
  output logic [4:0]          rs_o,
  output logic [4:0]          rt_o,
  output logic [4:0]          rd_o,
  output logic [4:0]          shamt_o,
  output logic [15:0]         imm_o
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  tgt_q, tgt_d;     // redirect target saved while draining
  logic [INSTR_W-1:0] skid_q, skid_d;   // only meaningful in S_HOLD

  logic               ifid_load;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_instr_in;

  logic [ADDR_W-1:0]  pc_next;
  logic [ADDR_W-1:0]  br_tgt;
  logic               xfer_rdy;

  // Wraps modulo 2^ADDR_W by construction.
  assign pc_next  = pc_q + ADDR_W'(PC_STEP);
  // Instructions are word aligned; low bits of the target are ignored.
  assign br_tgt   = {branch_target_i[ADDR_W-1:2], 2'b00};
  assign xfer_rdy = imem.rsp_rdy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      tgt_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    skid_d        = skid_q;
    ifid_load     = 1'b0;
    // A redirect always kills whatever is in IF/ID, stalled or not.
    ifid_flush    = branch_taken_i;
    ifid_instr_in = imem.rsp_dat;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (branch_taken_i) pc_d = br_tgt;
      end

      S_FETCH: begin
        if (xfer_rdy) begin
          if (branch_taken_i) begin
            pc_d = br_tgt;               // returned word is on the wrong path
          end else if (stall_i) begin
            skid_d  = imem.rsp_dat;      // PC advances when the skid drains
            state_d = S_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_next;
          end
        end else if (branch_taken_i) begin
          // Request cannot be withdrawn: let it complete, then discard it.
          tgt_d   = br_tgt;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (branch_taken_i) tgt_d = br_tgt;   // latest redirect wins
        if (xfer_rdy) begin
          pc_d    = branch_taken_i ? br_tgt : tgt_q;
          state_d = S_FETCH;
        end
      end

      S_HOLD: begin
        if (branch_taken_i) begin
          pc_d    = br_tgt;
          state_d = S_FETCH;
        end else if (!stall_i) begin
          ifid_load     = 1'b1;
          ifid_instr_in = skid_q;
          pc_d          = pc_next;
          state_d       = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign imem.req_vld  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem.req_addr = pc_q;

  ifid_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ifid_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (ifid_instr_in),
    .pc4_i   (pc_next),
    .valid_o (ifid_valid_o),
    .instr_o (ifid_instr_o),
    .pc4_o   (ifid_pc4_o)
  );

  instr_fields_t fields;
  assign fields   = decode_fields(ifid_instr_o[31:0]);
  assign opcode_o = fields.opcode;
  assign func_o   = fields.func;
  assign rs_o     = fields.rs;
  assign rt_o     = fields.rt;
  assign rd_o     = fields.rd;
  assign shamt_o  = fields.shamt;
  assign imm_o    = {fields.rd, fields.shamt, fields.func};

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
// Two instances share all stimulus: A resets its PC to 0, B to 0xFFFFFFFC for wrap checks.
// Inputs are driven just after a rising edge and outputs are compared 1 time unit after it.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        mem_rdy;
  logic [31:0] mem_dat;

  instr_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) ifa ();
  instr_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) ifb ();
  assign ifa.rsp_rdy = mem_rdy;
  assign ifa.rsp_dat = mem_dat;
  assign ifb.rsp_rdy = mem_rdy;
  assign ifb.rsp_dat = mem_dat;

  logic        a_vld, b_vld;
  logic [31:0] a_instr, b_instr, a_pc4, b_pc4;
  logic [5:0]  a_opc, b_opc, a_func, b_func;
  logic [4:0]  a_rs, b_rs, a_rt, b_rt, a_rd, b_rd, a_sh, b_sh;
  logic [15:0] a_imm, b_imm;

  instr_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .PC_RESET(32'h0), .PC_STEP(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .branch_taken_i(br), .branch_target_i(tgt),
    .imem(ifa), .ifid_valid_o(a_vld), .ifid_instr_o(a_instr), .ifid_pc4_o(a_pc4),
    .opcode_o(a_opc), .func_o(a_func), .rs_o(a_rs), .rt_o(a_rt), .rd_o(a_rd),
    .shamt_o(a_sh), .imm_o(a_imm)
  );

  instr_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .PC_RESET(32'hFFFF_FFFC), .PC_STEP(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .branch_taken_i(br), .branch_target_i(tgt),
    .imem(ifb), .ifid_valid_o(b_vld), .ifid_instr_o(b_instr), .ifid_pc4_o(b_pc4),
    .opcode_o(b_opc), .func_o(b_func), .rs_o(b_rs), .rt_o(b_rt), .rd_o(b_rd),
    .shamt_o(b_sh), .imm_o(b_imm)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model of instance A: next fetch address, a one-cycle warm-up after reset,
  // a pending redirect for a request that must still complete, and a queue of parked words.
  logic [31:0] m_pc;
  bit          m_warmup;
  bit          m_redir_vld;
  logic [31:0] m_redir;
  logic [31:0] m_parked[$];
  bit          m_vld;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  function automatic bit m_req();
    return !m_warmup && (m_parked.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_warmup = 1'b1; m_redir_vld = 1'b0; m_redir = 32'h0;
    m_parked.delete(); m_vld = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
  endtask

  task automatic model_step(input bit b, input logic [31:0] t, input bit s, input bit r,
                            input logic [31:0] d);
    logic [31:0] ta;
    ta = t & 32'hFFFF_FFFC;
    if (b) begin m_vld = 1'b0; m_instr = 32'h0; end
    if (m_warmup) begin
      m_warmup = 1'b0;
      if (b) m_pc = ta;
    end else if (m_parked.size() != 0) begin
      if (b) begin
        m_parked.delete(); m_pc = ta;
      end else if (!s) begin
        m_vld = 1'b1; m_instr = m_parked.pop_front(); m_pc = m_pc + 32'd4; m_pc4 = m_pc;
      end
    end else if (m_redir_vld) begin
      if (b) m_redir = ta;
      if (r) begin m_pc = m_redir; m_redir_vld = 1'b0; end
    end else if (r) begin
      if (b) m_pc = ta;
      else if (s) m_parked.push_back(d);
      else begin m_vld = 1'b1; m_instr = d; m_pc = m_pc + 32'd4; m_pc4 = m_pc; end
    end else if (b) begin
      m_redir_vld = 1'b1; m_redir = ta;
    end
  endtask

  // Apply one cycle of inputs, advance the model, return 1 unit after the rising edge.
  task automatic drive(input bit b, input logic [31:0] t, input bit s, input bit r,
                       input logic [31:0] d);
    br = b; tgt = t; stall = s; mem_rdy = r; mem_dat = d;
    model_step(b, t, s, r, d);
    @(posedge clk); #1;
    br = 1'b0; stall = 1'b0; mem_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; br = 1'b0; stall = 1'b0; mem_rdy = 1'b0; tgt = 32'h0; mem_dat = 32'h0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; br = 1'b0; stall = 1'b0; mem_rdy = 1'b1; tgt = 32'h0; mem_dat = 32'hFFFF_FFFF;
    model_reset();
    #23;
    checks++;
    if ({ifa.req_vld, ifa.req_addr} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_req_addr: got req=%b addr=%h want req=0 addr=00000000", ifa.req_vld, ifa.req_addr);
    end
    checks++;
    if ({a_vld, a_instr, a_pc4} !== {1'b0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL reset_ifid: got vld=%b instr=%h pc4=%h want 0/0/0", a_vld, a_instr, a_pc4);
    end
    checks++;
    if ({ifb.req_vld, ifb.req_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL reset_pc_b: got req=%b addr=%h want req=0 addr=fffffffc", ifb.req_vld, ifb.req_addr);
    end
    mem_rdy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(0, 0, 0, 0, 0);  // quiet cycle after reset
    checks++;
    if ({ifa.req_vld, ifa.req_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL basic_first_req: got req=%b addr=%h want 1/00000000", ifa.req_vld, ifa.req_addr);
    end
    drive(0, 0, 0, 1, 32'h2008_0005);  // addi $t0,$0,5
    checks++;
    if ({a_vld, a_opc, a_rs, a_rt, a_imm, a_pc4} !== {1'b1, 6'b001000, 5'd0, 5'd8, 16'd5, 32'h4}) begin
      errors++; $display("FAIL basic_decode: got vld=%b opc=%b rs=%0d rt=%0d imm=%h pc4=%h want 1/001000/0/8/0005/4",
                         a_vld, a_opc, a_rs, a_rt, a_imm, a_pc4);
    end
    checks++;
    if (ifa.req_addr !== 32'h4) begin
      errors++; $display("FAIL basic_addr4: got %h want 00000004", ifa.req_addr);
    end
    drive(0, 0, 0, 1, 32'h2009_000A);
    checks++;
    if ({ifa.req_addr, a_instr, a_pc4} !== {32'h8, 32'h2009_000A, 32'h8}) begin
      errors++; $display("FAIL basic_b2b: got addr=%h instr=%h pc4=%h want 8/2009000a/8", ifa.req_addr, a_instr, a_pc4);
    end
  endtask

  task automatic test_stall();
    drive(0, 0, 1, 1, 32'h012A_5820);  // word @8 arrives under stall
    checks++;
    if ({ifa.req_vld, a_instr, a_pc4} !== {1'b0, 32'h2009_000A, 32'h8}) begin
      errors++; $display("FAIL stall_capture: got req=%b instr=%h pc4=%h want 0/2009000a/8", ifa.req_vld, a_instr, a_pc4);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 0);
      checks++;
      if ({ifa.req_vld, a_instr} !== {1'b0, 32'h2009_000A}) begin
        errors++; $display("FAIL stall_hold%0d: got req=%b instr=%h want 0/2009000a", i, ifa.req_vld, a_instr);
      end
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({a_vld, a_instr, a_pc4, ifa.req_vld, ifa.req_addr} !== {1'b1, 32'h012A_5820, 32'hC, 1'b1, 32'hC}) begin
      errors++; $display("FAIL stall_release: got vld=%b instr=%h pc4=%h req=%b addr=%h want 1/012a5820/c/1/c",
                         a_vld, a_instr, a_pc4, ifa.req_vld, ifa.req_addr);
    end
  endtask

  task automatic test_branch_drain();
    drive(0, 0, 0, 1, 32'h8C0B_0004);  // now requesting 0x10
    drive(1, 32'h40, 0, 0, 0);
    checks++;
    if ({ifa.req_vld, ifa.req_addr, a_vld, a_instr} !== {1'b1, 32'h10, 1'b0, 32'h0}) begin
      errors++; $display("FAIL drain_enter: got req=%b addr=%h vld=%b instr=%h want 1/10/0/0",
                         ifa.req_vld, ifa.req_addr, a_vld, a_instr);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0);
      checks++;
      if ({ifa.req_vld, ifa.req_addr, a_vld} !== {1'b1, 32'h10, 1'b0}) begin
        errors++; $display("FAIL drain_hold%0d: got req=%b addr=%h vld=%b want 1/10/0", i, ifa.req_vld, ifa.req_addr, a_vld);
      end
    end
    drive(0, 0, 0, 1, 32'hDEAD_BEEF);
    checks++;
    if ({ifa.req_vld, ifa.req_addr, a_vld} !== {1'b1, 32'h40, 1'b0}) begin
      errors++; $display("FAIL drain_discard: got req=%b addr=%h vld=%b want 1/40/0", ifa.req_vld, ifa.req_addr, a_vld);
    end
    drive(0, 0, 0, 1, 32'h1540_FFFC);
    checks++;
    if ({a_vld, a_instr, a_pc4} !== {1'b1, 32'h1540_FFFC, 32'h44}) begin
      errors++; $display("FAIL drain_target_fetch: got vld=%b instr=%h pc4=%h want 1/1540fffc/44", a_vld, a_instr, a_pc4);
    end
  endtask

  task automatic test_branch_stall_rdy();
    drive(1, 32'h80, 1, 1, 32'hBADC_0DE5);
    checks++;
    if ({a_vld, a_instr, ifa.req_vld, ifa.req_addr} !== {1'b0, 32'h0, 1'b1, 32'h80}) begin
      errors++; $display("FAIL br_stall_rdy: got vld=%b instr=%h req=%b addr=%h want 0/0/1/80",
                         a_vld, a_instr, ifa.req_vld, ifa.req_addr);
    end
    drive(0, 0, 0, 1, 32'h0000_0020);
    checks++;
    if ({a_vld, a_instr, a_pc4} !== {1'b1, 32'h0000_0020, 32'h84}) begin
      errors++; $display("FAIL br_stall_next: got vld=%b instr=%h pc4=%h want 1/00000020/84", a_vld, a_instr, a_pc4);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({ifb.req_vld, ifb.req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", ifb.req_vld, ifb.req_addr);
    end
    drive(0, 0, 0, 1, 32'h0232_4025);
    checks++;
    if ({ifb.req_addr, b_vld, b_pc4} !== {32'h0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL wrap_second: got addr=%h vld=%b pc4=%h want 0/1/0", ifb.req_addr, b_vld, b_pc4);
    end
    checks++;
    if ({b_opc, b_rs, b_rt, b_rd, b_sh, b_func, b_imm, b_instr} !== {32'h0232_4025, 16'h4025, 32'h0232_4025}) begin
      errors++; $display("FAIL wrap_fields: got fields=%h imm=%h instr=%h want 02324025/4025/02324025",
                         {b_opc, b_rs, b_rt, b_rd, b_sh, b_func}, b_imm, b_instr);
    end
    drive(1, 32'h43, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h1111_1111);
    checks++;
    if ({ifb.req_addr, ifa.req_addr, b_vld} !== {32'h40, 32'h40, 1'b0}) begin
      errors++; $display("FAIL wrap_align: got b_addr=%h a_addr=%h vld=%b want 40/40/0", ifb.req_addr, ifa.req_addr, b_vld);
    end
  endtask

  task automatic test_reset_mid_drain();
    drive(1, 32'h100, 0, 0, 0);  // request @0x40 outstanding, now draining
    rst_n = 1'b0; mem_rdy = 1'b1; mem_dat = 32'hCAFE_F00D;
    model_reset();
    #1;
    checks++;
    if ({ifa.req_vld, ifa.req_addr, a_vld, a_instr, ifb.req_addr} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL rst_async: got req=%b addr=%h vld=%b instr=%h b_addr=%h want 0/0/0/0/fffffffc",
                         ifa.req_vld, ifa.req_addr, a_vld, a_instr, ifb.req_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 32'hCAFE_F00D);  // late response during quiet cycle
    checks++;
    if ({a_vld, ifa.req_vld, ifa.req_addr} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL rst_late_rdy: got vld=%b req=%b addr=%h want 0/1/0", a_vld, ifa.req_vld, ifa.req_addr);
    end
    drive(0, 0, 0, 1, 32'h2008_0005);
    checks++;
    if ({a_vld, a_instr, a_pc4} !== {1'b1, 32'h2008_0005, 32'h4}) begin
      errors++; $display("FAIL rst_restart: got vld=%b instr=%h pc4=%h want 1/20080005/4", a_vld, a_instr, a_pc4);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      drive(($urandom % 6) == 0, $urandom, ($urandom % 3) == 0, ($urandom % 2) == 1, $urandom);
      checks++;
      if ({ifa.req_vld, ifa.req_addr, a_vld, a_instr} !== {m_req(), m_pc, m_vld, m_instr}) begin
        errors++; $display("FAIL rand_state[%0d]: got req=%b addr=%h vld=%b instr=%h want %b/%h/%b/%h",
                           n, ifa.req_vld, ifa.req_addr, a_vld, a_instr, m_req(), m_pc, m_vld, m_instr);
      end
      if (m_vld) begin
        checks++;
        if (a_pc4 !== m_pc4) begin
          errors++; $display("FAIL rand_pc4[%0d]: got %h want %h", n, a_pc4, m_pc4);
        end
      end
      checks++;
      if ({a_opc, a_rs, a_rt, a_rd, a_sh, a_func, a_imm} !== {m_instr, m_instr[15:0]}) begin
        errors++; $display("FAIL rand_fields[%0d]: got %h/%h want %h/%h",
                           n, {a_opc, a_rs, a_rt, a_rd, a_sh, a_func}, a_imm, m_instr, m_instr[15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch_drain();
    test_branch_stall_rdy();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
